// File: rtl/anim_sequencer.sv
// Sprite animation frame sequencer: steps a frame index at a programmable period in
// loop/once/ping-pong/reverse modes and registers the {frame, y, x} ROM address.
module anim_sequencer #(
    parameter int FRAMES          = 16,
    parameter int FRAME_W         = 4,
    parameter int TICKS_PER_FRAME = 3_125_000,
    parameter int TICK_W          = 22,
    parameter int X_W             = 8,
    parameter int Y_W             = 8,
    parameter bit SYNC_EN         = 1'b1
) (
    input  logic                       clk_25,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       pause,
    input  logic [1:0]                 mode,
    input  logic                       frame_sync,
    input  logic [X_W-1:0]             pix_x,
    input  logic [Y_W-1:0]             pix_y,
    output logic [FRAME_W-1:0]         frame_idx,
    output logic                       frame_adv,
    output logic                       busy,
    output logic                       done,
    output logic [FRAME_W+Y_W+X_W-1:0] rom_addr
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [1:0] M_LOOP = 2'b00;
    localparam logic [1:0] M_ONCE = 2'b01;
    localparam logic [1:0] M_PING = 2'b10;

    localparam logic [FRAME_W-1:0] LAST      = FRAME_W'(FRAMES - 1);
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICKS_PER_FRAME - 1);

    logic [1:0]                       state_reg, state_next;
    logic [FRAME_W-1:0]               frame_reg, frame_next;
    logic [TICK_W-1:0]                tick_reg, tick_next;
    logic                             dir_reg, dir_next;   // 1 = counting down (ping-pong)
    logic                             pending_reg, pending_next;
    logic [1:0]                       mode_reg, mode_next;
    logic                             frame_adv_reg, frame_adv_next;
    logic                             done_reg, done_next;
    logic [FRAME_W+Y_W+X_W-1:0]       rom_addr_reg;
    logic                             adv;
    logic                             step;

    always_comb begin
        state_next     = state_reg;
        frame_next     = frame_reg;
        tick_next      = tick_reg;
        dir_next       = dir_reg;
        pending_next   = pending_reg;
        mode_next      = mode_reg;
        frame_adv_next = 1'b0;
        done_next      = 1'b0;
        adv            = 1'b0;
        step           = 1'b0;

        if (start) begin
            mode_next    = mode;
            frame_next   = (mode == 2'b11) ? LAST : '0;
            tick_next    = '0;
            dir_next     = 1'b0;
            pending_next = 1'b0;
            state_next   = S_RUN;
        end else if (stop) begin
            tick_next    = '0;
            pending_next = 1'b0;
            state_next   = S_IDLE;
        end else if (state_reg == S_RUN || state_reg == S_PAUSED) begin
            if (pause) begin
                state_next = S_PAUSED;
            end else begin
                // Releasing pause counts in the same cycle, so a pause of k cycles delays by exactly k.
                state_next = S_RUN;
                if (tick_reg == TICK_LAST) begin
                    tick_next = '0;
                    adv       = 1'b1;
                end else begin
                    tick_next = tick_reg + TICK_W'(1);
                end

                if (SYNC_EN) begin
                    step         = frame_sync && (pending_reg || adv);
                    pending_next = step ? 1'b0 : (pending_reg || adv);
                end else begin
                    step = adv;
                end

                if (step) begin
                    case (mode_reg)
                        M_LOOP: frame_next = (frame_reg == LAST) ? '0 : frame_reg + FRAME_W'(1);
                        M_ONCE: begin
                            if (frame_reg == LAST) begin
                                state_next = S_DONE;
                                done_next  = 1'b1;
                            end else begin
                                frame_next = frame_reg + FRAME_W'(1);
                            end
                        end
                        M_PING: begin
                            // End frames turn around without repeating; a single frame never moves.
                            if (!dir_reg) begin
                                if (frame_reg == LAST) begin
                                    dir_next = 1'b1;
                                    if (frame_reg != '0) frame_next = frame_reg - FRAME_W'(1);
                                end else begin
                                    frame_next = frame_reg + FRAME_W'(1);
                                end
                            end else begin
                                if (frame_reg == '0) begin
                                    dir_next = 1'b0;
                                    if (frame_reg != LAST) frame_next = frame_reg + FRAME_W'(1);
                                end else begin
                                    frame_next = frame_reg - FRAME_W'(1);
                                end
                            end
                        end
                        default: frame_next = (frame_reg == '0) ? LAST : frame_reg - FRAME_W'(1);
                    endcase
                    frame_adv_next = (frame_next != frame_reg);
                end
            end
        end
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            frame_reg     <= '0;
            tick_reg      <= '0;
            dir_reg       <= 1'b0;
            pending_reg   <= 1'b0;
            mode_reg      <= 2'b00;
            frame_adv_reg <= 1'b0;
            done_reg      <= 1'b0;
            rom_addr_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            frame_reg     <= frame_next;
            tick_reg      <= tick_next;
            dir_reg       <= dir_next;
            pending_reg   <= pending_next;
            mode_reg      <= mode_next;
            frame_adv_reg <= frame_adv_next;
            done_reg      <= done_next;
            rom_addr_reg  <= {frame_reg, pix_y, pix_x};
        end
    end

    assign frame_idx = frame_reg;
    assign frame_adv = frame_adv_reg;
    assign done      = done_reg;
    assign busy      = (state_reg == S_RUN) || (state_reg == S_PAUSED);
    assign rom_addr  = rom_addr_reg;
endmodule

// File: tb/tb_anim_sequencer.sv
// Directed bench for anim_sequencer: FRAMES=4, TICKS_PER_FRAME=4; one immediate-switch
// instance and one vblank-aligned instance sharing the control inputs.
module tb_anim_sequencer;
    logic        clk_25 = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pause = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        frame_sync = 1'b0;
    logic [7:0]  pix_x = 8'h00;
    logic [7:0]  pix_y = 8'h00;

    logic [3:0]  frame_idx, s_frame_idx;
    logic        frame_adv, s_frame_adv;
    logic        busy, s_busy;
    logic        done, s_done;
    logic [19:0] rom_addr, s_rom_addr;

    int vectors = 0;
    int miscompares = 0;

    always #20 clk_25 = ~clk_25;

    anim_sequencer #(
        .FRAMES(4), .FRAME_W(4), .TICKS_PER_FRAME(4), .TICK_W(4),
        .X_W(8), .Y_W(8), .SYNC_EN(1'b0)
    ) dut (
        .clk_25(clk_25), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .frame_sync(frame_sync), .pix_x(pix_x), .pix_y(pix_y),
        .frame_idx(frame_idx), .frame_adv(frame_adv), .busy(busy), .done(done),
        .rom_addr(rom_addr)
    );

    anim_sequencer #(
        .FRAMES(4), .FRAME_W(4), .TICKS_PER_FRAME(4), .TICK_W(4),
        .X_W(8), .Y_W(8), .SYNC_EN(1'b1)
    ) dut_sync (
        .clk_25(clk_25), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .frame_sync(frame_sync), .pix_x(pix_x), .pix_y(pix_y),
        .frame_idx(s_frame_idx), .frame_adv(s_frame_adv), .busy(s_busy), .done(s_done),
        .rom_addr(s_rom_addr)
    );

    task automatic step();
        @(posedge clk_25);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #5;
        vectors++;
        if ({frame_idx, frame_adv, busy, done, rom_addr} !== 27'd0) begin
            miscompares++;
            $display("FAIL reset_async: got frame=%0d adv=%0b busy=%0b done=%0b addr=%h required all 0",
                     frame_idx, frame_adv, busy, done, rom_addr);
        end
        step();
        step();
        rst = 1'b0;
        step();
        vectors++;
        if ({frame_idx, frame_adv, busy, done} !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_idle: got frame=%0d adv=%0b busy=%0b done=%0b required all 0",
                     frame_idx, frame_adv, busy, done);
        end
    endtask

    // Frames change every 4 edges after start; seq holds the frames expected at each change.
    task automatic test_run_modes(input logic [1:0] m);
        int seq[8];
        int len;
        int first;
        int exp_frame;
        case (m)
            2'b00:   begin seq = '{1, 2, 3, 0, 0, 0, 0, 0}; len = 4; first = 0; end
            2'b10:   begin seq = '{1, 2, 3, 2, 1, 0, 1, 0}; len = 7; first = 0; end
            default: begin seq = '{2, 1, 0, 3, 0, 0, 0, 0}; len = 4; first = 3; end
        endcase
        pulse_start(m);
        vectors++;
        if (frame_idx !== 4'(first) || frame_adv !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mode%0d_start: got frame=%0d adv=%0b busy=%0b required frame=%0d adv=0 busy=1",
                     m, frame_idx, frame_adv, busy, first);
        end
        exp_frame = first;
        for (int e = 1; e <= 4 * len; e++) begin
            step();
            if (e % 4 == 0) exp_frame = seq[e / 4 - 1];
            vectors++;
            if (frame_idx !== 4'(exp_frame) || frame_adv !== (e % 4 == 0) || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL mode%0d_edge%0d: got frame=%0d adv=%0b busy=%0b required frame=%0d adv=%0b busy=1",
                         m, e, frame_idx, frame_adv, busy, exp_frame, (e % 4 == 0));
            end
        end
    endtask

    task automatic test_once();
        int exp_frame;
        logic exp_done;
        logic exp_adv;
        pulse_start(2'b01);
        for (int e = 1; e <= 24; e++) begin
            step();
            exp_frame = (e / 4 > 3) ? 3 : e / 4;
            exp_done  = (e == 16);
            exp_adv   = (e % 4 == 0) && (e < 16);
            vectors++;
            if (frame_idx !== 4'(exp_frame) || done !== exp_done || frame_adv !== exp_adv
                || busy !== (e < 16)) begin
                miscompares++;
                $display("FAIL once_edge%0d: got frame=%0d done=%0b adv=%0b busy=%0b required frame=%0d done=%0b adv=%0b busy=%0b",
                         e, frame_idx, done, frame_adv, busy, exp_frame, exp_done, exp_adv, (e < 16));
            end
        end
    endtask

    task automatic test_pause();
        pulse_start(2'b00);
        repeat (9) step();
        pause = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            vectors++;
            if (frame_idx !== 4'd2 || frame_adv !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL pause_hold%0d: got frame=%0d adv=%0b busy=%0b required frame=2 adv=0 busy=1",
                         e, frame_idx, frame_adv, busy);
            end
        end
        pause = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            step();
            vectors++;
            if (frame_idx !== ((e == 3) ? 4'd3 : 4'd2) || frame_adv !== (e == 3)) begin
                miscompares++;
                $display("FAIL pause_resume%0d: got frame=%0d adv=%0b required frame=%0d adv=%0b",
                         e, frame_idx, frame_adv, (e == 3) ? 3 : 2, (e == 3));
            end
        end
    endtask

    task automatic test_stop();
        pulse_start(2'b00);
        repeat (4) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        vectors++;
        if (frame_idx !== 4'd1 || busy !== 1'b0 || frame_adv !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_enter: got frame=%0d busy=%0b adv=%0b required frame=1 busy=0 adv=0",
                     frame_idx, busy, frame_adv);
        end
        repeat (8) step();
        vectors++;
        if (frame_idx !== 4'd1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_hold: got frame=%0d busy=%0b required frame=1 busy=0", frame_idx, busy);
        end
        mode  = 2'b00;
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        vectors++;
        if (frame_idx !== 4'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_over_stop: got frame=%0d busy=%0b required frame=0 busy=1", frame_idx, busy);
        end
    endtask

    task automatic test_rom_addr_and_rst();
        pulse_start(2'b00);
        repeat (8) step();
        pix_x = 8'h12;
        pix_y = 8'h34;
        step();
        vectors++;
        if (rom_addr !== 20'h23412) begin
            miscompares++;
            $display("FAIL rom_addr: got %h required 23412", rom_addr);
        end
        #5 rst = 1'b1;
        #1;
        vectors++;
        if ({frame_idx, frame_adv, busy, done, rom_addr} !== 27'd0
            || {s_frame_idx, s_busy, s_rom_addr} !== 25'd0) begin
            miscompares++;
            $display("FAIL rst_midrun: got frame=%0d busy=%0b addr=%h sync_frame=%0d required all 0",
                     frame_idx, busy, rom_addr, s_frame_idx);
        end
        step();
        rst = 1'b0;
        pix_x = 8'h00;
        pix_y = 8'h00;
        repeat (6) step();
        vectors++;
        if (frame_idx !== 4'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_stays_idle: got frame=%0d busy=%0b required frame=0 busy=0", frame_idx, busy);
        end
    endtask

    // Sync at edge 2 has nothing pending; later syncs each collapse several period ends into one step.
    task automatic test_sync();
        int exp_frame;
        logic hit;
        pulse_start(2'b00);
        exp_frame = 0;
        for (int k = 1; k <= 30; k++) begin
            frame_sync = (k == 2) || (k == 10) || (k == 20) || (k == 30);
            step();
            frame_sync = 1'b0;
            hit = (k == 10) || (k == 20) || (k == 30);
            if (hit) exp_frame++;
            vectors++;
            if (s_frame_idx !== 4'(exp_frame) || s_frame_adv !== hit || s_busy !== 1'b1) begin
                miscompares++;
                $display("FAIL sync_edge%0d: got frame=%0d adv=%0b busy=%0b required frame=%0d adv=%0b busy=1",
                         k, s_frame_idx, s_frame_adv, s_busy, exp_frame, hit);
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_modes(2'b00);
        test_once();
        test_run_modes(2'b10);
        test_run_modes(2'b11);
        test_pause();
        test_stop();
        test_sync();
        test_rom_addr_and_rst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
